// File: rtl/alu_seq_if.sv
// Request/response channel of alu_seq: operands and funct in, registered result and flags out.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       funct;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             flagZ;
  logic             flagN;
  logic             flagC;
  logic             flagV;
  logic             err;
  logic             busy;

  modport master (
    output in_valid, A, B, funct, out_ready,
    input  in_ready, out_valid, out, flagZ, flagN, flagC, flagV, err, busy
  );

  modport slave (
    input  in_valid, A, B, funct, out_ready,
    output in_ready, out_valid, out, flagZ, flagN, flagC, flagV, err, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked sequential ALU with registered result and flags.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (funct 1001).
module alu_seq #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input logic      clock,
  input logic      reset,
  alu_seq_if.slave bus
);
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [3:0] FAdd = 4'b0000;
  localparam logic [3:0] FSub = 4'b0001;
  localparam logic [3:0] FAnd = 4'b0010;
  localparam logic [3:0] FOr  = 4'b0011;
  localparam logic [3:0] FXor = 4'b0100;
  localparam logic [3:0] FNot = 4'b0101;
  localparam logic [3:0] FSla = 4'b0110;
  localparam logic [3:0] FSra = 4'b0111;
  localparam logic [3:0] FSrl = 4'b1000;
`ifdef ALU_MUL_EN
  localparam logic [3:0] FMul = 4'b1001;
  localparam int unsigned CntW = $clog2(WIDTH);
`endif

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a, r_b;
  logic [3:0]       r_funct;
  logic [WIDTH-1:0] r_out;
  logic             r_z, r_n, r_c, r_v, r_err;

  logic [WIDTH:0]     w_add, w_sub;
  logic [WIDTH-1:0]   w_res;
  logic               w_c, w_v, w_err, w_res_ready;
  logic [SHAMT_W-1:0] w_shamt;

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] r_acc;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] w_mul_next;

  // r_a/r_b double as multiplicand (shifted left) and multiplier (shifted right).
  assign w_mul_next  = r_acc + (r_b[0] ? r_a : '0);
  assign w_res_ready = (r_funct != FMul) || (r_cnt == CntW'(WIDTH - 1));
`else
  assign w_res_ready = 1'b1;
`endif

  assign w_shamt = r_b[SHAMT_W-1:0];

  always_comb begin
    w_add = {1'b0, r_a} + {1'b0, r_b};
    w_sub = {1'b0, r_a} + {1'b0, ~r_b} + (WIDTH + 1)'(1);
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_err = 1'b0;
    case (r_funct)
      FAdd: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_add[WIDTH-1] != r_a[WIDTH-1]);
      end
      FSub: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_sub[WIDTH-1] != r_a[WIDTH-1]);
      end
      FAnd: w_res = r_a & r_b;
      FOr:  w_res = r_a | r_b;
      FXor: w_res = r_a ^ r_b;
      FNot: w_res = ~r_a;
      FSla: w_res = r_a << w_shamt;
      FSra: w_res = $signed(r_a) >>> w_shamt;
      FSrl: w_res = r_a >> w_shamt;
`ifdef ALU_MUL_EN
      FMul: w_res = w_mul_next;
`endif
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_funct <= '0;
      r_out   <= '0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
      r_err   <= 1'b0;
`ifdef ALU_MUL_EN
      r_acc   <= '0;
      r_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_state <= StExec;
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_funct <= bus.funct;
`ifdef ALU_MUL_EN
            r_acc   <= '0;
            r_cnt   <= '0;
`endif
          end
        end
        StExec: begin
          if (w_res_ready) begin
            r_state <= StDone;
            r_out   <= w_res;
            r_z     <= (w_res == '0);
            r_n     <= w_res[WIDTH-1];
            r_c     <= w_c;
            r_v     <= w_v;
            r_err   <= w_err;
          end else begin
`ifdef ALU_MUL_EN
            r_acc <= w_mul_next;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + CntW'(1);
`endif
          end
        end
        StDone: begin
          if (bus.out_ready) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.out_valid = (r_state == StDone);
  assign bus.busy      = (r_state == StExec);
  assign bus.out       = r_out;
  assign bus.flagZ     = r_z;
  assign bus.flagN     = r_n;
  assign bus.flagC     = r_c;
  assign bus.flagV     = r_v;
  assign bus.err       = r_err;
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the combinational ALU. It accepts one operation at a time over a valid/ready input channel and registers the result with full condition flags. The result is returned over a valid/ready output channel. It sits between the decode stage and writeback in the multi-cycle datapath, and adds an iterative shift-add multiplier, which is optional at compile time.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 4)
- SHAMT_W, $clog2(WIDTH), number of B bits used as shift amount
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  operation request valid
- in_ready  output  1  block can accept an operation
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- funct  input  4  operation select
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out  output  WIDTH  registered result
- flagZ / flagN / flagC / flagV  output  1 each  zero / negative / carry / signed-overflow
- err  output  1  illegal funct was issued
- busy  output  1  operation in progress (state EXEC)

## Operation
- FSM states: IDLE, EXEC, DONE.
  - IDLE: in_ready=1.
  - IDLE→EXEC on in_valid&&in_ready. A, B and funct are captured on that edge.
  - EXEC→DONE when the result is registered.
  - DONE→IDLE on out_valid&&out_ready.
- in_ready is high only in IDLE. Inputs are ignored in EXEC and DONE.
- funct encoding:
  - 0000 ADD: A+B
  - 0001 SUB: A−B
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 NOT: ~A
  - 0110 SLA: A<<B[SHAMT_W-1:0], zero fill
  - 0111 SRA: arithmetic right shift, sign fill
  - 1000 SRL: logical right shift, zero fill
  - 1001 MUL: low WIDTH bits of A*B, unsigned
  - 1010–1111: illegal
- Shifts use only B[SHAMT_W-1:0]. Upper bits of B are ignored.
- MUL runs iteratively, one multiplier bit per cycle, using a shift-add accumulator over exactly WIDTH cycles.
- Illegal funct: out=0, err=1, flagZ=1, flagN=flagC=flagV=0. Latency is the same as a single-cycle op.
- Flags are registered together with out:
  - flagZ = (out==0)
  - flagN = out[WIDTH-1]
  - flagC:
    - ADD: carry out of bit WIDTH-1.
    - SUB: carry of A+~B+1, so 1 means no borrow (A ≥ B unsigned).
    - All other ops: 0.
  - flagV: signed overflow for ADD/SUB; 0 for all other ops.
  - err=0 for every legal op.
- out, the flags and err hold stable from entry to DONE until the next result is registered.

## Timing
- Reset (asynchronous assert, synchronous-to-clock release):
  - state=IDLE
  - out=0, flagZ=flagN=flagC=flagV=0, err=0
  - out_valid=0, busy=0
  - in_ready=1
- Single-cycle ops: accept at edge N; result and out_valid=1 registered at edge N+1.
- MUL: accept at edge N; out_valid=1 at edge N+WIDTH. busy=1 for WIDTH cycles.
- Backpressure: in DONE with out_ready=0, out_valid stays 1 and all outputs stay frozen.
- Handoff: on the edge where out_valid&&out_ready, the FSM enters IDLE and in_ready=1 in the following cycle. Minimum issue interval is 3 cycles for single-cycle ops.
- Reset asserted mid-EXEC (including mid-MUL) or mid-DONE: the operation is abandoned, all outputs return to reset values immediately, and no partial result is ever presented.
- in_valid held high across a completed transaction starts a new operation only once the FSM is back in IDLE.

## Configuration
- ALU_MUL_EN defined: the multiplier datapath and counter are compiled in, and funct 1001 performs MUL as above.
- ALU_MUL_EN undefined: no multiplier logic is generated. funct 1001 is treated as illegal (err=1, out=0, 1-cycle latency).

## Test plan
- ADD, WIDTH=32, A=5, B=7 → out=12 one edge after accept; Z=N=C=V=0; in_ready low until out_ready handshake.
- SUB, A=−10, B=5 → out=0xFFFFFFF1, N=1, C=1, V=0. ADD 0x7FFFFFFF+1 → out=0x80000000, N=1, V=1, C=0.
- SRA A=−12, B=2 → 0xFFFFFFFD. SRL A=0xAAAAAAAA, B=0x24 (shift 4) → 0x0AAAAAAA. XOR 15,15 → out=0, Z=1.
- MUL (ALU_MUL_EN) A=7, B=6 → out=42 exactly 32 edges after accept. Hold out_ready=0 for 3 cycles → out, flags and out_valid stay stable.
- funct=1011 → out=0, err=1, Z=1. Rebuild without ALU_MUL_EN: funct=1001 → err=1.
- Reset pulse on cycle 10 of a MUL → all outputs at reset values, in_ready=1. Next ADD 1+1 → out=2 with normal latency.
